delayed_io_countdown: RTL

- Single-channel delay countdown engine. One instance per output, inside the delayed I/O controller.
- Consumes the controller's one-cycle start strobe and the delay value, already converted to processing-clock cycles.
- Signals completion with a one-cycle done pulse, on which the controller applies the pending delayed set/clear.
- Also provides cancel, restart-while-running, remaining-count readback and wrapping event counters for status registers.

---
 rtl/delayed_io_countdown.sv | 102 ++++++++++
 1 files changed

// File: rtl/delayed_io_countdown.sv
// Single-channel delay countdown: a start loads a cycle count, a one-cycle done pulse follows expiry.
// Supports cancel, restart-while-running, remaining-count readback and wrapping event counters.
module delayed_io_countdown #(
    parameter int W_CNT  = 32,
    parameter int W_STAT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_start,
    input  logic              i_cancel,
    input  logic [W_CNT-1:0]  i_delay_cycles,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_io_busy,
    output logic [W_CNT-1:0]  o_remaining,
    output logic [W_STAT-1:0] o_done_count,
    output logic [W_STAT-1:0] o_cancel_count,
    output logic [W_STAT-1:0] o_restart_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [W_CNT-1:0]  CNT_ONE  = W_CNT'(1);
    localparam logic [W_STAT-1:0] STAT_ONE = W_STAT'(1);

    state_t              state_q, state_d;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic [W_STAT-1:0]   done_cnt_q, done_cnt_d;
    logic [W_STAT-1:0]   cancel_cnt_q, cancel_cnt_d;
    logic [W_STAT-1:0]   restart_cnt_q, restart_cnt_d;
    logic [W_CNT-1:0]    load_val;

    // A zero delay still produces one busy cycle before done.
    assign load_val = (i_delay_cycles == '0) ? CNT_ONE : i_delay_cycles;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_cnt_d    = done_cnt_q;
        cancel_cnt_d  = cancel_cnt_q;
        restart_cnt_d = restart_cnt_q;
        if (!i_enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (i_cancel && state_q == S_COUNT) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            cancel_cnt_d = cancel_cnt_q + STAT_ONE;
        end else if (i_start) begin
            state_d = S_COUNT;
            cnt_d   = load_val;
            if (state_q == S_COUNT) begin
                restart_cnt_d = restart_cnt_q + STAT_ONE;
            end
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (cnt_q == CNT_ONE) begin
                        // Counted on entry so the status reflects the pulse in the same cycle.
                        state_d    = S_DONE;
                        cnt_d      = '0;
                        done_cnt_d = done_cnt_q + STAT_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            done_cnt_q    <= '0;
            cancel_cnt_q  <= '0;
            restart_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            done_cnt_q    <= done_cnt_d;
            cancel_cnt_q  <= cancel_cnt_d;
            restart_cnt_q <= restart_cnt_d;
        end
    end

    assign o_busy          = (state_q == S_COUNT);
    assign o_done          = (state_q == S_DONE);
    assign o_io_busy       = o_busy | o_done;
    assign o_remaining     = o_busy ? cnt_q : '0;
    assign o_done_count    = done_cnt_q;
    assign o_cancel_count  = cancel_cnt_q;
    assign o_restart_count = restart_cnt_q;

endmodule
